// File: rtl/alu_share_arbiter_if.sv
// Request, response and ALU-side signals of the shared-ALU arbiter.
// master: issue logic, response consumer and ALU; slave: the arbiter.
interface alu_share_arbiter_if #(
    parameter int unsigned DATA_W = 32
);
    logic              req0_valid_i;
    logic              req0_ready_o;
    logic [DATA_W-1:0] req0_data1_i;
    logic [DATA_W-1:0] req0_data2_i;
    logic [2:0]        req0_ctrl_i;

    logic              req1_valid_i;
    logic              req1_ready_o;
    logic [DATA_W-1:0] req1_data1_i;
    logic [DATA_W-1:0] req1_data2_i;
    logic [2:0]        req1_ctrl_i;

    logic              resp_valid_o;
    logic              resp_ready_i;
    logic              resp_id_o;
    logic [DATA_W-1:0] resp_data_o;
    logic              resp_err_o;

    logic [DATA_W-1:0] alu_data1_o;
    logic [DATA_W-1:0] alu_data2_o;
    logic [2:0]        alu_ctrl_o;
    logic [DATA_W-1:0] alu_data_i;

    modport master (
        output req0_valid_i, req0_data1_i, req0_data2_i, req0_ctrl_i,
        output req1_valid_i, req1_data1_i, req1_data2_i, req1_ctrl_i,
        output resp_ready_i, alu_data_i,
        input  req0_ready_o, req1_ready_o,
        input  resp_valid_o, resp_id_o, resp_data_o, resp_err_o,
        input  alu_data1_o, alu_data2_o, alu_ctrl_o
    );

    modport slave (
        input  req0_valid_i, req0_data1_i, req0_data2_i, req0_ctrl_i,
        input  req1_valid_i, req1_data1_i, req1_data2_i, req1_ctrl_i,
        input  resp_ready_i, alu_data_i,
        output req0_ready_o, req1_ready_o,
        output resp_valid_o, resp_id_o, resp_data_o, resp_err_o,
        output alu_data1_o, alu_data2_o, alu_ctrl_o
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one ALU between two requesters; one op in flight,
// mul held on the ALU ports for MUL_CYCLES cycles, result on a valid/ready channel.
module alu_share_arbiter #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MUL_CYCLES = 3
) (
    input logic                clk_i,
    input logic                rst_i,
    alu_share_arbiter_if.slave bus
);
    localparam int unsigned CntW        = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [2:0]  CtrlMul     = 3'b101;
    localparam logic [2:0]  CtrlIllegal = 3'b111;

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e            r_state;
    logic              r_last_grant;
    logic [CntW-1:0]   r_cnt;
    logic              r_resp_valid;
    logic              r_resp_id;
    logic [DATA_W-1:0] r_resp_data;
    logic              r_resp_err;
    logic [DATA_W-1:0] r_alu_data1;
    logic [DATA_W-1:0] r_alu_data2;
    logic [2:0]        r_alu_ctrl;

    logic              w_grant0;
    logic              w_grant1;
    logic              w_hs;
    logic              w_id;
    logic [DATA_W-1:0] w_data1;
    logic [DATA_W-1:0] w_data2;
    logic [2:0]        w_ctrl;

    // When both are valid, the requester that did not win last time gets the grant.
    assign w_grant0 = bus.req0_valid_i & (~bus.req1_valid_i | r_last_grant);
    assign w_grant1 = bus.req1_valid_i & (~bus.req0_valid_i | ~r_last_grant);
    assign w_hs     = ~rst_i & (r_state == StIdle) & (w_grant0 | w_grant1);
    assign w_id     = w_grant1;
    assign w_data1  = w_id ? bus.req1_data1_i : bus.req0_data1_i;
    assign w_data2  = w_id ? bus.req1_data2_i : bus.req0_data2_i;
    assign w_ctrl   = w_id ? bus.req1_ctrl_i  : bus.req0_ctrl_i;

    assign bus.req0_ready_o = ~rst_i & (r_state == StIdle) & w_grant0;
    assign bus.req1_ready_o = ~rst_i & (r_state == StIdle) & w_grant1;
    assign bus.resp_valid_o = r_resp_valid;
    assign bus.resp_id_o    = r_resp_id;
    assign bus.resp_data_o  = r_resp_data;
    assign bus.resp_err_o   = r_resp_err;
    assign bus.alu_data1_o  = r_alu_data1;
    assign bus.alu_data2_o  = r_alu_data2;
    assign bus.alu_ctrl_o   = r_alu_ctrl;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= StIdle;
            r_last_grant <= 1'b1;
            r_cnt        <= '0;
            r_resp_valid <= 1'b0;
            r_resp_id    <= 1'b0;
            r_resp_data  <= '0;
            r_resp_err   <= 1'b0;
            r_alu_data1  <= '0;
            r_alu_data2  <= '0;
            r_alu_ctrl   <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_hs) begin
                        r_last_grant <= w_id;
                        r_resp_id    <= w_id;
                        if (w_ctrl == CtrlIllegal) begin
                            // Illegal code never reaches the ALU; its ports keep old values.
                            r_resp_data  <= '0;
                            r_resp_err   <= 1'b1;
                            r_resp_valid <= 1'b1;
                            r_state      <= StResp;
                        end else begin
                            r_alu_data1 <= w_data1;
                            r_alu_data2 <= w_data2;
                            r_alu_ctrl  <= w_ctrl;
                            r_cnt       <= (w_ctrl == CtrlMul) ? CntW'(MUL_CYCLES - 1) : '0;
                            r_state     <= StExec;
                        end
                    end
                end
                StExec: begin
                    if (r_cnt == '0) begin
                        r_resp_data  <= bus.alu_data_i;
                        r_resp_err   <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_state      <= StResp;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                StResp: begin
                    if (bus.resp_ready_i) begin
                        r_resp_valid <= 1'b0;
                        r_state      <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural ALU on the ALU ports.
module tb_alu_share_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   n_pass  = 0;
    int   n_total = 0;

    alu_share_arbiter_if #(.DATA_W(32)) bus ();

    alu_share_arbiter #(
        .DATA_W    (32),
        .MUL_CYCLES(3)
    ) u_dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] c);
        case (c)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return a & b;
            3'b011:  return a | b;
            3'b100:  return a ^ b;
            3'b101:  return a * b;
            3'b110:  return {31'b0, $signed(a) < $signed(b)};
            default: return 32'h0;
        endcase
    endfunction

    assign bus.alu_data_i = alu_f(bus.alu_data1_o, bus.alu_data2_o, bus.alu_ctrl_o);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input bit which, input bit v, input logic [2:0] c,
                           input logic [31:0] a, input logic [31:0] b);
        if (which) begin
            bus.req1_valid_i = v; bus.req1_ctrl_i = c;
            bus.req1_data1_i = a; bus.req1_data2_i = b;
        end else begin
            bus.req0_valid_i = v; bus.req0_ctrl_i = c;
            bus.req0_data1_i = a; bus.req0_data2_i = b;
        end
    endtask

    // Present a request, confirm it is the one granted, cross the handshake edge.
    task automatic issue(input bit which, input logic [2:0] c, input logic [31:0] a,
                         input logic [31:0] b, input string tag);
        set_req(which, 1'b1, c, a, b);
        @(negedge clk);
        check({tag, "_rdy0"}, {31'b0, bus.req0_ready_o}, {31'b0, ~which});
        check({tag, "_rdy1"}, {31'b0, bus.req1_ready_o}, {31'b0, which});
        tick();
        set_req(which, 1'b0, c, a, b);
    endtask

    task automatic wait_resp(input string tag, input int exp_lat, input logic [31:0] d,
                             input logic id, input logic err);
        int lat = 0;
        for (int i = 1; i <= 16 && lat == 0; i++) begin
            @(negedge clk);
            if (bus.resp_valid_o) lat = i;
        end
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_data"}, bus.resp_data_o, d);
        check({tag, "_id"}, {31'b0, bus.resp_id_o}, {31'b0, id});
        check({tag, "_err"}, {31'b0, bus.resp_err_o}, {31'b0, err});
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        bus.resp_ready_i = 1'b1;
        set_req(1'b0, 1'b1, 3'b000, 32'd1, 32'd1);
        set_req(1'b1, 1'b1, 3'b000, 32'd1, 32'd1);

        // Reset state, with both requesters valid.
        @(negedge clk);
        check("rst_rdy0", {31'b0, bus.req0_ready_o}, 32'd0);
        check("rst_rdy1", {31'b0, bus.req1_ready_o}, 32'd0);
        check("rst_valid", {31'b0, bus.resp_valid_o}, 32'd0);
        check("rst_data", bus.resp_data_o, 32'd0);
        check("rst_alu_ctrl", {29'b0, bus.alu_ctrl_o}, 32'd0);
        check("rst_alu_d1", bus.alu_data1_o, 32'd0);
        set_req(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        set_req(1'b1, 1'b0, 3'b000, 32'd0, 32'd0);
        tick();
        rst = 1'b0;

        // Single add from req0.
        issue(1'b0, 3'b000, 32'd5, 32'd7, "t1");
        wait_resp("t1", 2, 32'd12, 1'b0, 1'b0);

        // Both valid right after reset: req0 first, then req1, then req0 again.
        do_reset();
        set_req(1'b1, 1'b1, 3'b100, 32'hF0, 32'h0F);
        issue(1'b0, 3'b001, 32'd10, 32'd3, "t2a");
        wait_resp("t2a", 2, 32'd7, 1'b0, 1'b0);
        issue(1'b1, 3'b100, 32'hF0, 32'h0F, "t2b");
        wait_resp("t2b", 2, 32'hFF, 1'b1, 1'b0);
        set_req(1'b1, 1'b1, 3'b011, 32'h1, 32'h2);
        issue(1'b0, 3'b010, 32'hC, 32'hA, "t2c");
        set_req(1'b1, 1'b0, 3'b011, 32'h1, 32'h2);
        wait_resp("t2c", 2, 32'h8, 1'b0, 1'b0);

        // Mul from req1: ctrl held on the ALU for three EXEC cycles.
        issue(1'b1, 3'b101, 32'd6, 32'd7, "t3");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t3_exec_ctrl", {29'b0, bus.alu_ctrl_o}, 32'd5);
            check("t3_exec_nvalid", {31'b0, bus.resp_valid_o}, 32'd0);
        end
        @(negedge clk);
        check("t3_valid", {31'b0, bus.resp_valid_o}, 32'd1);
        check("t3_data", bus.resp_data_o, 32'd42);
        check("t3_id", {31'b0, bus.resp_id_o}, 32'd1);
        tick();

        // Illegal ctrl: error response, ALU ports untouched.
        issue(1'b0, 3'b111, 32'd9, 32'd9, "t4");
        wait_resp("t4", 1, 32'd0, 1'b0, 1'b1);
        check("t4_alu_ctrl", {29'b0, bus.alu_ctrl_o}, 32'd5);
        check("t4_alu_d1", bus.alu_data1_o, 32'd6);
        check("t4_alu_d2", bus.alu_data2_o, 32'd7);

        // Back-pressure on the response channel with req1 waiting.
        bus.resp_ready_i = 1'b0;
        issue(1'b0, 3'b000, 32'd1, 32'd2, "t5a");
        set_req(1'b1, 1'b1, 3'b000, 32'd100, 32'd23);
        @(negedge clk);
        check("t5_exec_nvalid", {31'b0, bus.resp_valid_o}, 32'd0);
        @(negedge clk);
        check("t5_valid", {31'b0, bus.resp_valid_o}, 32'd1);
        check("t5_data", bus.resp_data_o, 32'd3);
        for (int i = 0; i < 5; i++) begin
            tick();
            @(negedge clk);
            check("t5_hold_valid", {31'b0, bus.resp_valid_o}, 32'd1);
            check("t5_hold_data", bus.resp_data_o, 32'd3);
            check("t5_hold_rdy0", {31'b0, bus.req0_ready_o}, 32'd0);
            check("t5_hold_rdy1", {31'b0, bus.req1_ready_o}, 32'd0);
        end
        tick();
        bus.resp_ready_i = 1'b1;
        @(negedge clk);
        check("t5_rel_valid", {31'b0, bus.resp_valid_o}, 32'd1);
        check("t5_rel_rdy1", {31'b0, bus.req1_ready_o}, 32'd0);
        tick();
        issue(1'b1, 3'b000, 32'd100, 32'd23, "t5b");
        wait_resp("t5b", 2, 32'd123, 1'b1, 1'b0);

        // Reset during mul EXEC: outputs clear at once, no response, req0 wins afterwards.
        issue(1'b0, 3'b101, 32'd3, 32'd4, "t6");
        @(negedge clk);
        check("t6_exec_ctrl", {29'b0, bus.alu_ctrl_o}, 32'd5);
        #2;
        rst = 1'b1;
        set_req(1'b0, 1'b1, 3'b000, 32'd2, 32'd2);
        set_req(1'b1, 1'b1, 3'b000, 32'd1, 32'd1);
        #1;
        check("t6_rst_alu_ctrl", {29'b0, bus.alu_ctrl_o}, 32'd0);
        check("t6_rst_alu_d1", bus.alu_data1_o, 32'd0);
        check("t6_rst_data", bus.resp_data_o, 32'd0);
        check("t6_rst_id", {31'b0, bus.resp_id_o}, 32'd0);
        check("t6_rst_rdy0", {31'b0, bus.req0_ready_o}, 32'd0);
        check("t6_rst_rdy1", {31'b0, bus.req1_ready_o}, 32'd0);
        set_req(1'b0, 1'b0, 3'b000, 32'd2, 32'd2);
        set_req(1'b1, 1'b0, 3'b000, 32'd1, 32'd1);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t6_no_resp", {31'b0, bus.resp_valid_o}, 32'd0);
            tick();
        end
        set_req(1'b1, 1'b1, 3'b000, 32'd1, 32'd1);
        issue(1'b0, 3'b000, 32'd2, 32'd2, "t6c");
        set_req(1'b1, 1'b0, 3'b000, 32'd1, 32'd1);
        wait_resp("t6c", 2, 32'd4, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
